// File: rtl/hawk_pkg.sv
// rtl/hawk_pkg.sv - state encoding and default dwell values for the hawk sequencer
package hawk_pkg;

  typedef enum logic [2:0] {
    ST_DARK     = 3'd0,
    ST_FLASH_Y  = 3'd1,
    ST_STEADY_Y = 3'd2,
    ST_RED_HOLD = 3'd3,
    ST_WALK     = 3'd4,
    ST_CLEAR    = 3'd5
  } hawk_state_e;

  localparam int TIMER_W        = 4;
  localparam int DEF_FLASH_Y_T  = 4;
  localparam int DEF_STEADY_Y_T = 3;
  localparam int DEF_RED_HOLD_T = 1;
  localparam int DEF_MIN_DARK_T = 10;

  // A zero dwell would stall the sequence, so it is promoted to one tick.
  function automatic logic [TIMER_W-1:0] at_least_one(input logic [TIMER_W-1:0] v);
    return (v == '0) ? TIMER_W'(1) : v;
  endfunction

endpackage

// File: rtl/hawk_dwell_timer.sv
// rtl/hawk_dwell_timer.sv - loadable tick-enabled down counter with last-tick strobe
module hawk_dwell_timer
  import hawk_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  // High during the tick that takes the count from 1 to 0.
  assign expire_o = tick_i && (count_q == TIMER_W'(1));

endmodule

// File: rtl/hawk_sequencer.sv
// rtl/hawk_sequencer.sv - pedestrian hybrid beacon sequencer, DARK through CLEAR
module hawk_sequencer
  import hawk_pkg::*;
#(
  parameter int FLASH_Y_T  = DEF_FLASH_Y_T,
  parameter int STEADY_Y_T = DEF_STEADY_Y_T,
  parameter int RED_HOLD_T = DEF_RED_HOLD_T,
  parameter int MIN_DARK_T = DEF_MIN_DARK_T
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               ped_req,
  input  logic [TIMER_W-1:0] walk_time,
  input  logic [TIMER_W-1:0] clear_time,
  output logic               yl_flash,
  output logic               yl_solid,
  output logic               rl_solid,
  output logic               rl_flash,
  output logic               walk,
  output logic               dnw,
  output logic               dnw_flash,
  output logic [TIMER_W-1:0] countdown,
  output logic               busy,
  output logic               req_pending
);

  hawk_state_e        state_q, state_d;
  logic               phase_q, phase_d;
  logic               req_q, req_d;
  logic [TIMER_W-1:0] walk_q, walk_d;
  logic [TIMER_W-1:0] clear_q, clear_d;

  logic               dt_load;
  logic [TIMER_W-1:0] dt_load_val;
  logic [TIMER_W-1:0] dt_count;
  logic               dt_expire;
  logic               md_load;
  logic [TIMER_W-1:0] md_count;
  logic               md_expire_unused;

  hawk_dwell_timer u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .load_i     (dt_load),
    .load_val_i (dt_load_val),
    .count_o    (dt_count),
    .expire_o   (dt_expire)
  );

  hawk_dwell_timer u_min_dark (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .load_i     (md_load),
    .load_val_i (TIMER_W'(MIN_DARK_T)),
    .count_o    (md_count),
    .expire_o   (md_expire_unused)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    walk_d      = walk_q;
    clear_d     = clear_q;
    req_d       = req_q | ped_req;
    md_load     = 1'b0;
    dt_load     = 1'b0;
    dt_load_val = '0;

    case (state_q)
      ST_DARK: begin
        if ((req_q || ped_req) && (md_count == '0)) begin
          state_d = ST_FLASH_Y;
          req_d   = 1'b0;
          walk_d  = at_least_one(walk_time);
          clear_d = at_least_one(clear_time);
        end
      end
      ST_FLASH_Y:  if (dt_expire) state_d = ST_STEADY_Y;
      ST_STEADY_Y: if (dt_expire) state_d = ST_RED_HOLD;
      ST_RED_HOLD: if (dt_expire) state_d = ST_WALK;
      ST_WALK:     if (dt_expire) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (dt_expire) begin
          state_d = ST_DARK;
          md_load = 1'b1;
        end
      end
      default: state_d = ST_DARK;
    endcase

    // Every state change reloads the dwell timer and re-seeds the flash phase.
    if (state_d != state_q) begin
      dt_load = 1'b1;
      case (state_d)
        ST_FLASH_Y:  dt_load_val = TIMER_W'(FLASH_Y_T);
        ST_STEADY_Y: dt_load_val = TIMER_W'(STEADY_Y_T);
        ST_RED_HOLD: dt_load_val = TIMER_W'(RED_HOLD_T);
        ST_WALK:     dt_load_val = walk_q;
        ST_CLEAR:    dt_load_val = clear_q;
        default:     dt_load_val = '0;
      endcase
      phase_d = (state_d == ST_FLASH_Y) || (state_d == ST_CLEAR);
    end else if (tick && ((state_q == ST_FLASH_Y) || (state_q == ST_CLEAR))) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DARK;
      phase_q <= 1'b0;
      req_q   <= 1'b0;
      walk_q  <= '0;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      req_q   <= req_d;
      walk_q  <= walk_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    yl_flash  = 1'b0;
    yl_solid  = 1'b0;
    rl_solid  = 1'b0;
    rl_flash  = 1'b0;
    walk      = 1'b0;
    dnw       = 1'b0;
    dnw_flash = 1'b0;
    countdown = '0;
    case (state_q)
      ST_DARK:     dnw = 1'b1;
      ST_FLASH_Y: begin
        yl_flash = phase_q;
        dnw      = 1'b1;
      end
      ST_STEADY_Y: begin
        yl_solid = 1'b1;
        dnw      = 1'b1;
      end
      ST_RED_HOLD: begin
        rl_solid = 1'b1;
        dnw      = 1'b1;
      end
      ST_WALK: begin
        rl_solid = 1'b1;
        walk     = 1'b1;
      end
      ST_CLEAR: begin
        rl_flash  = phase_q;
        dnw_flash = phase_q;
        countdown = dt_count;
      end
      default: dnw = 1'b1;
    endcase
  end

  assign busy        = (state_q != ST_DARK);
  assign req_pending = req_q;

endmodule

// File: tb/tb_hawk_sequencer.sv
// tb/tb_hawk_sequencer.sv - randomized bench for hawk_sequencer against a tick-level model
module tb_hawk_sequencer;

  localparam int FLASH_T = 4;
  localparam int STEADY_T = 3;
  localparam int RED_T = 1;
  localparam int DARK_T = 10;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       ped_req;
  logic [3:0] walk_time;
  logic [3:0] clear_time;
  logic       yl_flash, yl_solid, rl_solid, rl_flash;
  logic       walk, dnw, dnw_flash, busy, req_pending;
  logic [3:0] countdown;

  int checks = 0;
  int failures = 0;

  // Model: stage index 0..5 = DARK, FLASH_Y, STEADY_Y, RED_HOLD, WALK, CLEAR.
  int m_st, m_rem, m_dark, m_wt, m_ct;
  bit m_pend, m_ph;

  hawk_sequencer #(
    .FLASH_Y_T (FLASH_T),
    .STEADY_Y_T(STEADY_T),
    .RED_HOLD_T(RED_T),
    .MIN_DARK_T(DARK_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ped_req    (ped_req),
    .walk_time  (walk_time),
    .clear_time (clear_time),
    .yl_flash   (yl_flash),
    .yl_solid   (yl_solid),
    .rl_solid   (rl_solid),
    .rl_flash   (rl_flash),
    .walk       (walk),
    .dnw        (dnw),
    .dnw_flash  (dnw_flash),
    .countdown  (countdown),
    .busy       (busy),
    .req_pending(req_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int dwell_of(input int st);
    case (st)
      1: return FLASH_T;
      2: return STEADY_T;
      3: return RED_T;
      4: return m_wt;
      5: return m_ct;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] act_vec();
    return {3'b0, yl_flash, yl_solid, rl_solid, rl_flash, walk, dnw, dnw_flash,
            busy, req_pending, countdown};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic flashing;
    flashing = (m_st == 1 || m_st == 5) && m_ph;
    return {3'b0, (m_st == 1) && flashing, m_st == 2, m_st == 3 || m_st == 4,
            (m_st == 5) && flashing, m_st == 4, m_st <= 3, (m_st == 5) && flashing,
            m_st != 0, m_pend, (m_st == 5) ? 4'(m_rem) : 4'd0};
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_dark = 0; m_pend = 0; m_ph = 0; m_wt = 0; m_ct = 0;
  endtask

  task automatic model_step();
    if (m_st == 0) begin
      if ((m_pend || ped_req) && m_dark == 0) begin
        m_st   = 1;
        m_rem  = FLASH_T;
        m_ph   = 1;
        m_pend = 0;
        m_wt   = (walk_time == 0) ? 1 : int'(walk_time);
        m_ct   = (clear_time == 0) ? 1 : int'(clear_time);
      end else begin
        m_pend = m_pend || ped_req;
        if (tick && m_dark > 0) m_dark--;
      end
    end else begin
      m_pend = m_pend || ped_req;
      if (tick) begin
        if (m_rem == 1) begin
          m_st = (m_st == 5) ? 0 : m_st + 1;
          if (m_st == 0) begin
            m_dark = DARK_T;
            m_rem  = 0;
            m_ph   = 0;
          end else begin
            m_rem = dwell_of(m_st);
            m_ph  = (m_st == 1 || m_st == 5);
          end
        end else begin
          m_rem--;
          if (m_st == 1 || m_st == 5) m_ph = !m_ph;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("outs", act_vec(), exp_vec());
  endtask

  // Reset lands between edges so the asynchronous path is what gets observed.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_outs", act_vec(), exp_vec());
    check("rst_dark", {15'b0, dnw & ~busy}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    int guard;
    bit pressed;
    rst_n = 1'b0;
    tick = 1'b0;
    ped_req = 1'b0;
    walk_time = 4'd5;
    clear_time = 4'd4;
    model_reset();
    #3;
    check("por", act_vec(), exp_vec());
    @(negedge clk);
    rst_n = 1'b1;

    // Single service: 4+3+1+5+4 ticks from FLASH_Y back to DARK.
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    check("svc_start", {14'b0, busy, yl_flash}, 16'b11);
    ticks = 0;
    pressed = 0;
    for (guard = 0; guard < 200; guard++) begin
      tick = guard[0];
      if (walk && !pressed) begin
        ped_req = 1'b1;
        pressed = 1;
      end
      cycle();
      ped_req = 1'b0;
      if (tick) ticks++;
      if (!busy) break;
    end
    check("svc_ticks", 16'(ticks), 16'd17);
    check("held_req", {15'b0, req_pending}, 16'd1);

    // The request raised during WALK waits out the minimum dark period.
    ticks = 0;
    for (guard = 0; guard < 200; guard++) begin
      tick = guard[0];
      cycle();
      if (busy) break;
      if (tick) ticks++;
    end
    check("min_dark", 16'(ticks), 16'd10);

    // Reset mid-WALK, then a fresh request is taken on the next edge.
    for (guard = 0; guard < 200 && !walk; guard++) begin
      tick = guard[0];
      cycle();
    end
    check("reach_walk", {15'b0, walk}, 16'd1);
    tick = 1'b0;
    do_reset();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    check("post_rst_svc", {15'b0, busy}, 16'd1);

    for (int i = 0; i < 4000; i++) begin
      tick       = ($urandom_range(0, 2) == 0);
      ped_req    = ($urandom_range(0, 24) == 0);
      walk_time  = 4'($urandom_range(0, 15));
      clear_time = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
